// File: rtl/lsu_ctrl.sv
// Load/store controller: latches one core data access, runs it as a byte-enabled
// word bus transaction, formats load data and reports misaligned/illegal/timed-out accesses.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        core_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          mis_q, mis_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          size_legal;
  logic          addr_misaligned;
  logic          stall_raw;

  function automatic logic [31:0] fmt_load(input logic [2:0] size, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (size)
      3'd0:    fmt_load = {{24{lane[7]}}, lane[7:0]};
      3'd4:    fmt_load = {24'h0, lane[7:0]};
      3'd1:    fmt_load = {{16{lane[15]}}, lane[15:0]};
      3'd5:    fmt_load = {16'h0, lane[15:0]};
      default: fmt_load = word;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0, 3'd4: byte_en = 4'b0001 << off;
      3'd1, 3'd5: byte_en = 4'b0011 << off;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      3'd0, 3'd4: lane_data = {4{wd[7:0]}};
      3'd1, 3'd5: lane_data = {2{wd[15:0]}};
      default:    lane_data = wd;
    endcase
  endfunction

  always_comb begin
    size_legal = (core_size_i == 3'd0) || (core_size_i == 3'd1) || (core_size_i == 3'd2) ||
                 (core_size_i == 3'd4) || (core_size_i == 3'd5);
    case (core_size_i)
      3'd1, 3'd5: addr_misaligned = core_addr_i[0];
      3'd2:       addr_misaligned = (core_addr_i[1:0] != 2'b00);
      default:    addr_misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'h0;
      wd_q    <= 32'h0;
      count_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      count_q <= count_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    size_d          = size_q;
    addr_d          = addr_q;
    wd_d            = wd_q;
    count_d         = count_q;
    err_d           = err_q;
    mis_d           = mis_q;
    rdata_d         = rdata_q;
    stall_raw       = 1'b0;
    core_rd_o       = 32'h0;
    core_err_o      = 1'b0;
    core_misalign_o = 1'b0;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_be_o        = 4'h0;
    mem_addr_o      = 32'h0;
    mem_wd_o        = 32'h0;

    case (state_q)
      IDLE: begin
        stall_raw = core_req_i;
        if (core_req_i) begin
          we_d    = core_we_i;
          size_d  = core_size_i;
          addr_d  = core_addr_i;
          wd_d    = core_wd_i;
          count_d = '0;
          err_d   = 1'b0;
          mis_d   = 1'b0;
          rdata_d = 32'h0;
          if (!size_legal) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (addr_misaligned) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_raw  = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = we_q;
        mem_be_o   = byte_en(size_q, addr_q[1:0]);
        mem_addr_o = {addr_q[31:2], 2'b00};
        mem_wd_o   = lane_data(size_q, wd_q);
        // A ready arriving in the last allowed cycle still completes normally.
        if (mem_ready_i) begin
          rdata_d = fmt_load(size_q, addr_q[1:0], mem_rd_i);
          state_d = DONE;
        end else if ((TIMEOUT != 0) && (count_q == CW'(TIMEOUT - 1))) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        core_rd_o       = rdata_q;
        core_err_o      = err_q;
        core_misalign_o = mis_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the stall low immediately even while the core keeps requesting.
  assign core_stall_o = stall_raw & rst_ni;

endmodule
